// File: rtl/uart_reg_responder.sv
// Byte-command register responder behind a UART: 'W' addr data writes, 'R' addr reads,
// and each command gets exactly one reply byte.
module uart_reg_responder #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic [7:0] reg0_out,
    output logic       cmd_err
);

    localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    OP_W     = 8'h57;
    localparam logic [7:0]    OP_R     = 8'h52;
    localparam logic [7:0]    RSP_BAD  = 8'h3F;
    localparam logic [7:0]    RSP_ADDR = 8'h21;
    localparam logic [7:0]    RSP_OK   = 8'h4B;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_EXEC, S_SEND, S_WAIT_HI, S_WAIT_LO
    } state_t;

    state_t         r_state, w_next;
    logic           r_rx_rdy_d;
    logic           r_is_wr;
    logic           r_bad_op;
    logic [7:0]     r_addr;
    logic [7:0]     r_wdata;
    logic [7:0]     r_tx_data;
    logic [TW-1:0]  r_tmo_cnt;
    logic [7:0]     r_regs [16];

    logic           w_accept;
    logic           w_addr_bad;
    logic           w_tmo_hit;
    logic           w_do_write;
    logic           w_collecting;
    logic [7:0]     w_rsp;

    // A held rx_rdy level is one byte: only the low-to-high transition is taken.
    assign w_accept     = rx_rdy & ~r_rx_rdy_d;
    assign w_addr_bad   = |r_addr[7:4];
    assign w_tmo_hit    = (r_tmo_cnt == TMO_LAST);
    assign w_collecting = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    assign w_do_write   = (r_state == S_EXEC) && r_is_wr && !r_bad_op && !w_addr_bad;
    assign tx_data      = r_tx_data;
    assign reg0_out     = r_regs[0];

    always_comb begin
        w_rsp = r_regs[r_addr[3:0]];
        if (r_bad_op)        w_rsp = RSP_BAD;
        else if (w_addr_bad) w_rsp = RSP_ADDR;
        else if (r_is_wr)    w_rsp = RSP_OK;
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    always_comb begin
        w_next  = r_state;
        tx_wr   = 1'b0;
        cmd_err = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = (rx_data == OP_W || rx_data == OP_R) ? S_GET_ADDR : S_EXEC;
            end
            S_GET_ADDR: begin
                if (w_accept)       w_next = r_is_wr ? S_GET_DATA : S_EXEC;
                else if (w_tmo_hit) w_next = S_IDLE;
            end
            S_GET_DATA: begin
                if (w_accept)       w_next = S_EXEC;
                else if (w_tmo_hit) w_next = S_IDLE;
            end
            S_EXEC: begin
                cmd_err = r_bad_op | w_addr_bad;
                w_next  = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_wr  = 1'b1;
                    w_next = S_WAIT_HI;
                end
            end
            S_WAIT_HI: if (tx_busy)  w_next = S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_rdy_d <= 1'b0;
            r_is_wr    <= 1'b0;
            r_bad_op   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_tx_data  <= '0;
            r_tmo_cnt  <= '0;
            // NOTE: the register file is cleared on reset because its contents are readable right after.
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else begin
            r_rx_rdy_d <= rx_rdy;
            if (r_state == S_IDLE && w_accept) begin
                r_is_wr  <= (rx_data == OP_W);
                r_bad_op <= !(rx_data == OP_W || rx_data == OP_R);
            end
            if (r_state == S_GET_ADDR && w_accept) r_addr  <= rx_data;
            if (r_state == S_GET_DATA && w_accept) r_wdata <= rx_data;
            if (r_state == S_EXEC)                 r_tx_data <= w_rsp;
            if (w_do_write)                        r_regs[r_addr[3:0]] <= r_wdata;
            if (w_accept || !w_collecting) r_tmo_cnt <= '0;
            else                           r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

endmodule

// File: doc/uart_reg_responder.md
UART_REG_RESPONDER -- requirements
Module: uart_reg_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000, inter-byte timeout in clk cycles for a partial command.
REQ-002 SHALL have ports:
  - clk  input  1  system clock, all logic on rising edge.
  - reset  input  1  synchronous, active-low reset.
  - rx_rdy  input  1  byte-valid from UART receiver.
  - rx_data  input  8  received byte, valid while rx_rdy high.
  - tx_busy  input  1  UART transmitter busy.
  - tx_wr  output  1  one-cycle transmit request.
  - tx_data  output  8  byte to transmit.
  - reg0_out  output  8  live copy of register 0.
  - cmd_err  output  1  one-cycle pulse on a rejected command.
REQ-003 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-004 SHALL accept a byte only on a rising edge of rx_rdy (rx_rdy high, previous-cycle rx_rdy low); a level held high SHALL count as one byte.
REQ-005 SHALL hold an internal register file of 16 x 8 bits, indexed by addr[3:0].
REQ-006 SHALL implement FSM states IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_HI, WAIT_LO.
REQ-007 In IDLE, an accepted byte SHALL be handled as follows:
  - 0x57 ('W') or 0x52 ('R'): latch the opcode, go to GET_ADDR.
  - any other byte: go to EXEC with error response 0x3F ('?').
REQ-008 In GET_ADDR, an accepted byte SHALL be latched as the address:
  - opcode 'W': go to GET_DATA.
  - opcode 'R': go to EXEC.
REQ-009 In GET_DATA, an accepted byte SHALL be latched as the write data, then go to EXEC.
REQ-010 EXEC SHALL last exactly one cycle and select the response:
  - address bits [7:4] nonzero: response 0x21 ('!'), no write, cmd_err pulse.
  - 'W' with valid address: write the register, response 0x4B ('K').
  - 'R' with valid address: response is the register contents.
  - invalid opcode: response 0x3F, cmd_err pulse.
REQ-011 EXEC SHALL load tx_data with the response, then go to SEND.
REQ-012 In SEND:
  - tx_busy low: assert tx_wr for exactly one cycle, go to WAIT_HI.
  - tx_busy high: stay in SEND with tx_wr low.
REQ-013 WAIT_HI SHALL go to WAIT_LO when tx_busy is high; WAIT_LO SHALL go to IDLE when tx_busy is low.
REQ-014 tx_data SHALL stay stable from EXEC until the FSM returns to IDLE.
REQ-015 Bytes accepted in EXEC, SEND, WAIT_HI or WAIT_LO SHALL be discarded without effect.
REQ-016 Latency: final command byte accepted at cycle N -> EXEC at N+1 -> tx_wr high at N+2 if tx_busy is low then.
REQ-017 A timeout counter SHALL clear on every accepted byte and count while in GET_ADDR or GET_DATA.
REQ-018 When the timeout counter reaches TIMEOUT_CYC-1, the FSM SHALL return to IDLE with no response, no write and no cmd_err.
REQ-019 A register write and a same-cycle read of reg0_out SHALL show the old value; the new value SHALL appear the following cycle.
REQ-020 cmd_err SHALL pulse exactly one cycle per rejected command and SHALL be low otherwise.

Reset
REQ-021 While reset is low at a clk edge, the block SHALL set:
  - FSM to IDLE.
  - all 16 registers, reg0_out, tx_data, tx_wr, cmd_err and the timeout counter to 0.
  - the stored rx_rdy edge-detect history to 0.
REQ-022 Reset asserted mid-command or mid-response SHALL abort it with no register write, and tx_wr SHALL be low on the next cycle.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Bytes 0x57,0x00,0xA5 -> exactly one tx_wr with tx_data=0x4B; reg0_out=0xA5.
  - After writing 0x3C to address 0x07, bytes 0x52,0x07 -> tx_data=0x3C; no other register changes.
  - Byte 0x41 -> tx_data=0x3F with one cmd_err pulse. Bytes 0x57,0x12,0xFF -> tx_data=0x21, cmd_err pulse, no register changes.
  - TIMEOUT_CYC=16; byte 0x57 followed by 16 idle cycles -> FSM back in IDLE, no tx_wr; then 0x52,0x00 -> valid reply.
  - tx_busy held high for 50 cycles at SEND -> tx_wr stays low, then pulses exactly once; an rx_rdy edge during WAIT_LO is discarded.
  - rx_rdy held high 10 cycles -> one byte accepted; reset low mid-GET_DATA -> all outputs 0 and the register is unwritten.
